trachtenberg_pipe_mul: RTL and testbench
========================================

# trachtenberg_pipe_mul

- Parametrised, fully pipelined unsigned multiplier using Trachtenberg column-wise (cross-product) multiplication.
- Computes one result column per pipeline stage. Accepts one new operand pair per clock and carries operands, partial result and carry with each item through the pipeline.
- Adds per-stage valid tracking, downstream backpressure and synchronous reset.
- Sits in the arithmetic datapath as the general replacement for the fixed-width column multipliers.

## Interface
Parameters:
- WIDTH, 5, operand width in bits; legal range 2..32.

Ports:
- iclk  input  1  clock; all state updates on rising edge.
- irst_n  input  1  reset; synchronous, active-low.
- ia  input  WIDTH  operand A, unsigned.
- ib  input  WIDTH  operand B, unsigned.
- istart  input  1  input valid; the pair is accepted on an edge where istart && oready.
- oready  output  1  pipeline can accept; combinational, equals !(ovalid && !iready).
- iready  input  1  downstream accepts ores on an edge where ovalid && iready.
- ores  output  2*WIDTH  product ia*ib.
- ovalid  output  1  ores holds a valid product.

## Operation
Pipeline shape:
- The pipeline has N = 2*WIDTH-1 stages, S0..S(N-1). Stage k handles column k.
- Each stage register holds: valid bit, a copy of a and b, result bits [k:0], and a carry.
- Carry width CW = $clog2(WIDTH)+2.

Stage k computation:
- col = sum of a[i]&b[k-i] over all i with 0<=i<WIDTH and 0<=k-i<WIDTH, plus carry_in.
- carry_in for S0 is 0.
- Stage stores res[k] = col[0] and carry_out = col>>1.
- S(N-1) also stores res[2*WIDTH-1] = col[1].

Data movement:
- Operands travel with their item, so new istart data never corrupts items in flight.
- ores is driven from the S(N-1) result field. ovalid is the S(N-1) valid bit.

Stall:
- Global enable: advance = !(ovalid && !iready).
- When advance=0, every stage register holds, including payload and valid.
- Bubbles are not compacted during a stall.

Acceptance:
- On an edge where advance=1, S0 loads valid=istart. Operands load only if istart=1.
- An istart presented while oready=0 is ignored; the source must hold it.

Arithmetic:
- All unsigned.
- Result is exact for all operands: 0..(2^WIDTH-1)^2.

## Timing
- Reset: on an edge with irst_n=0, all stage valid bits, results, carries and operand copies clear to 0.
  - Afterwards ovalid=0, ores=0, oready=1.
  - Reset mid-operation discards every item in flight; no partial result is emitted.
- Latency: a pair accepted at edge E appears with ovalid=1 after edge E+N-1 (no stalls).
  - That is N = 2*WIDTH-1 cycles after acceptance, counting the accept edge as cycle 1.
  - WIDTH=5 gives 9 cycles.
- Throughput: one item per clock while iready=1.
- Each stall cycle adds exactly one cycle to the latency of every item in flight.
- ovalid && !iready: ores and ovalid stay stable and oready=0 in the same cycle.
- iready=0 with ovalid=0: pipeline keeps advancing; bubbles drain and items move forward.
- istart and output acceptance on the same edge: both happen; no loss, no duplication.
- Input ordering is preserved at the output.

## Structure
- Package trachtenberg_pkg holds:
  - function carry_width(WIDTH) returning CW;
  - function column_sum(a, b, k), the cross-product popcount for column k;
  - localparam helpers for N.
- Sub-module trachtenberg_column_stage (parameters WIDTH, COL) is one pipeline stage: registers, column adder and enable/reset.
  - The top generates N instances and the advance/oready logic.

## Test plan
- Reset: hold irst_n=0 for 3 cycles with istart=1 -> ovalid=0, ores=0, oready=1; no output appears after release until a new accept.
- WIDTH=5, single pair 31*31, iready=1 -> ores=961 with ovalid high exactly 9 cycles after the accept edge, for one cycle only.
- WIDTH=5, back-to-back stream ia=0..31, ib=31-ia -> 32 consecutive valid outputs in order, each equal to ia*(31-ia), no gaps.
- Backpressure: stream of 12 items, iready low for 4 cycles while ovalid=1 -> ores held stable, oready=0 during the stall, all 12 products delivered in order with no loss or duplication.
- Reset mid-flight: 5 items accepted, irst_n pulsed low 1 cycle at cycle 4 -> no valid output from those items; a following 3*7 appears as 21 at normal latency.
- WIDTH=8: 255*255 -> 65025; 0*200 -> 0; 128*2 -> 256; each at 15-cycle latency.

Source files
------------

// File: rtl/trachtenberg_pkg.sv
// rtl/trachtenberg_pkg.sv - shared sizing helpers and column cross-product sum
package trachtenberg_pkg;

    localparam int MAX_WIDTH = 32;

    function automatic int carry_width(input int width);
        return $clog2(width) + 2;
    endfunction

    function automatic int num_stages(input int width);
        return 2 * width - 1;
    endfunction

    // Popcount of a[i]&b[k-i] over every in-range i; the result fits 8 bits for width <= 32.
    function automatic logic [7:0] column_sum(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int                   k,
        input int                   width
    );
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width && (k - i) >= 0 && (k - i) < width) begin
                s = s + 8'(a[i] & b[k - i]);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/trachtenberg_pipe_mul_if.sv
// rtl/trachtenberg_pipe_mul_if.sv - per-item payload carried between column stages
interface trachtenberg_pipe_mul_if
    import trachtenberg_pkg::*;
#(
    parameter int WIDTH = 5
) ();

    localparam int CW = carry_width(WIDTH);

    logic                 valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   res;
    logic [CW-1:0]        carry;

    modport master (
        output valid,
        output a,
        output b,
        output res,
        output carry
    );

    modport slave (
        input valid,
        input a,
        input b,
        input res,
        input carry
    );

endinterface

// File: rtl/trachtenberg_column_stage.sv
// rtl/trachtenberg_column_stage.sv - one pipeline stage resolving product column COL
module trachtenberg_column_stage
    import trachtenberg_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int COL   = 0
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    advance_i,
    trachtenberg_pipe_mul_if.slave  up,
    trachtenberg_pipe_mul_if.master dn
);

    localparam int CW = carry_width(WIDTH);
    localparam int N  = num_stages(WIDTH);

    logic                 valid_q;
    logic                 valid_d;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   res_q;
    logic [2*WIDTH-1:0]   res_d;
    logic [CW-1:0]        carry_q;
    logic [CW-1:0]        carry_d;
    logic [7:0]           col_sum;

    always_comb begin
        col_sum = column_sum(32'(up.a), 32'(up.b), COL, WIDTH) + 8'(up.carry);
        valid_d = up.valid;
        carry_d = CW'(col_sum >> 1);
        res_d   = up.res;
        res_d[COL] = col_sum[0];
        // The last column has no successor, so its carry's low bit becomes the product MSB.
        if (COL == N - 1) begin
            res_d[2*WIDTH-1] = col_sum[1];
        end
    end

    // Payload is only captured for real items so bubbles never disturb held data.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
        end else if (advance_i) begin
            valid_q <= valid_d;
            if (up.valid) begin
                a_q     <= up.a;
                b_q     <= up.b;
                res_q   <= res_d;
                carry_q <= carry_d;
            end
        end
    end

    assign dn.valid = valid_q;
    assign dn.a     = a_q;
    assign dn.b     = b_q;
    assign dn.res   = res_q;
    assign dn.carry = carry_q;

endmodule

// File: rtl/trachtenberg_pipe_mul.sv
// rtl/trachtenberg_pipe_mul.sv - pipelined unsigned multiplier, one product column per stage
module trachtenberg_pipe_mul
    import trachtenberg_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic [WIDTH-1:0]     ia,
    input  logic [WIDTH-1:0]     ib,
    input  logic                 istart,
    output logic                 oready,
    input  logic                 iready,
    output logic [2*WIDTH-1:0]   ores,
    output logic                 ovalid
);

    localparam int N = num_stages(WIDTH);

    // link[k] feeds stage k; link[N] is the output of the final stage.
    trachtenberg_pipe_mul_if #(.WIDTH(WIDTH)) link [N+1] ();

    logic advance;
    logic unused_tail;

    // One global enable: the whole pipe freezes only when the output is blocked.
    assign advance = !(ovalid && !iready);
    assign oready  = advance;

    assign link[0].valid = istart;
    assign link[0].a     = ia;
    assign link[0].b     = ib;
    assign link[0].res   = '0;
    assign link[0].carry = '0;

    for (genvar k = 0; k < N; k++) begin : g_stage
        trachtenberg_column_stage #(
            .WIDTH (WIDTH),
            .COL   (k)
        ) u_stage (
            .clk_i     (iclk),
            .resetn_i  (irst_n),
            .advance_i (advance),
            .up        (link[k]),
            .dn        (link[k+1])
        );
    end

    assign ores   = link[N].res;
    assign ovalid = link[N].valid;

    assign unused_tail = ^{link[N].a, link[N].b, link[N].carry};

endmodule

// File: tb/tb_trachtenberg_pipe_mul.sv
// tb/tb_trachtenberg_pipe_mul.sv - directed vector bench for trachtenberg_pipe_mul
module tb_trachtenberg_pipe_mul;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst5, iready5, oready5, ovalid5;
    logic [9:0]  ores5;
    logic        rst8, iready8, oready8, ovalid8;
    logic [15:0] ores8;

    trachtenberg_pipe_mul_if #(.WIDTH(5)) in5 ();
    trachtenberg_pipe_mul_if #(.WIDTH(8)) in8 ();

    trachtenberg_pipe_mul #(.WIDTH(5)) dut5 (
        .iclk   (clk),
        .irst_n (rst5),
        .ia     (in5.a),
        .ib     (in5.b),
        .istart (in5.valid),
        .oready (oready5),
        .iready (iready5),
        .ores   (ores5),
        .ovalid (ovalid5)
    );

    trachtenberg_pipe_mul #(.WIDTH(8)) dut8 (
        .iclk   (clk),
        .irst_n (rst8),
        .ia     (in8.a),
        .ib     (in8.b),
        .istart (in8.valid),
        .oready (oready8),
        .iready (iready8),
        .ores   (ores8),
        .ovalid (ovalid8)
    );

    int total = 0;
    int bad   = 0;
    int n_out5 = 0;
    int seen5  = 0;
    logic [9:0] sb5[$];
    vec_t v5[5];
    vec_t v8[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: handshakes are decided by values stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (!rst5) begin
            sb5.delete();
        end else begin
            if (ovalid5) seen5++;
            if (ovalid5 && iready5) begin
                if (sb5.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb5_unexpected actual=%0d required=no_output", ores5);
                end else begin
                    chk("sb5_product", 64'(ores5), 64'(sb5.pop_front()));
                    n_out5++;
                end
            end
            if (in5.valid && oready5) sb5.push_back(10'(in5.a) * 10'(in5.b));
        end
    end

    task automatic push5(input logic [4:0] a, input logic [4:0] b);
        bit acc;
        int guard;
        in5.a = a;
        in5.b = b;
        in5.valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            acc = oready5;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("push5_timeout", 0, 1);
    endtask

    task automatic lat5(input logic [4:0] a, input logic [4:0] b, input logic [9:0] p, input string nm);
        int cnt;
        push5(a, b);
        in5.valid = 1'b0;
        cnt = 1;
        while (cnt < 40) begin
            @(negedge clk);
            if (ovalid5) break;
            @(posedge clk);
            cnt++;
        end
        chk({nm, "_lat"}, 64'(cnt), 64'd9);
        chk({nm, "_res"}, 64'(ores5), 64'(p));
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_one_cycle"}, 64'(ovalid5), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input string nm);
        int cnt;
        in8.a = a;
        in8.b = b;
        in8.valid = 1'b1;
        @(posedge clk);
        #1;
        in8.valid = 1'b0;
        cnt = 1;
        while (cnt < 60) begin
            @(negedge clk);
            if (ovalid8) break;
            @(posedge clk);
            cnt++;
        end
        chk({nm, "_lat"}, 64'(cnt), 64'd15);
        chk({nm, "_res"}, 64'(ores8), 64'(p));
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_one_cycle"}, 64'(ovalid8), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int snap;
        logic [9:0] held;

        v5[0] = '{8'd31, 8'd31, 16'd961};
        v5[1] = '{8'd0,  8'd0,  16'd0};
        v5[2] = '{8'd1,  8'd31, 16'd31};
        v5[3] = '{8'd17, 8'd19, 16'd323};
        v5[4] = '{8'd30, 8'd29, 16'd870};
        v8[0] = '{8'd255, 8'd255, 16'd65025};
        v8[1] = '{8'd0,   8'd200, 16'd0};
        v8[2] = '{8'd128, 8'd2,   16'd256};
        v8[3] = '{8'd13,  8'd17,  16'd221};

        in5.res = '0; in5.carry = '0;
        in8.res = '0; in8.carry = '0;
        rst5 = 1'b0; rst8 = 1'b0;
        iready5 = 1'b1; iready8 = 1'b1;
        in5.valid = 1'b1; in5.a = 5'd5; in5.b = 5'd6;
        in8.valid = 1'b1; in8.a = 8'd9; in8.b = 8'd10;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst5_ovalid", 64'(ovalid5), 64'd0);
        chk("rst5_ores",   64'(ores5),   64'd0);
        chk("rst5_oready", 64'(oready5), 64'd1);
        chk("rst8_ovalid", 64'(ovalid8), 64'd0);
        chk("rst8_ores",   64'(ores8),   64'd0);
        @(posedge clk);
        #1;
        rst5 = 1'b1; rst8 = 1'b1;
        in5.valid = 1'b0; in8.valid = 1'b0;
        snap = seen5;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset_idle", 64'(seen5 - snap), 64'd0);

        for (int i = 0; i < 5; i++) begin
            lat5(v5[i].a[4:0], v5[i].b[4:0], v5[i].p[9:0], $sformatf("w5_vec%0d", i));
        end

        start = n_out5;
        fork
            begin
                for (int i = 0; i < 32; i++) push5(5'(i), 5'(31 - i));
                in5.valid = 1'b0;
            end
            begin
                int w;
                int gaps;
                w = 0;
                gaps = 0;
                @(negedge clk);
                while (!ovalid5 && w < 30) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 32; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!ovalid5) gaps++;
                end
                @(negedge clk);
                chk("stream_tail", 64'(ovalid5), 64'd0);
                chk("stream_gaps", 64'(gaps), 64'd0);
            end
        join
        @(posedge clk);
        #1;
        chk("stream_count", 64'(n_out5 - start), 64'd32);

        start = n_out5;
        fork
            begin
                for (int i = 0; i < 12; i++) push5(5'(i + 3), 5'(2 * i + 1));
                in5.valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!ovalid5 && w < 40) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                chk("stall_found_output", 64'(ovalid5), 64'd1);
                iready5 = 1'b0;
                held = ores5;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_hold_ores", 64'(ores5), 64'(held));
                    chk("stall_oready",    64'(oready5), 64'd0);
                    chk("stall_ovalid",    64'(ovalid5), 64'd1);
                    @(posedge clk);
                    #1;
                end
                iready5 = 1'b1;
            end
        join
        repeat (25) @(posedge clk);
        #1;
        chk("bp_count", 64'(n_out5 - start), 64'd12);
        chk("bp_drained", 64'(sb5.size()), 64'd0);

        for (int i = 0; i < 5; i++) push5(5'(i + 1), 5'(i + 2));
        in5.valid = 1'b0;
        rst5 = 1'b0;
        @(posedge clk);
        #1;
        rst5 = 1'b1;
        snap = seen5;
        @(negedge clk);
        chk("midrst_ovalid", 64'(ovalid5), 64'd0);
        chk("midrst_ores",   64'(ores5),   64'd0);
        chk("midrst_oready", 64'(oready5), 64'd1);
        @(posedge clk);
        #1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'(seen5 - snap), 64'd0);
        lat5(5'd3, 5'd7, 10'd21, "after_rst");

        for (int i = 0; i < 4; i++) begin
            lat8(v8[i].a, v8[i].b, v8[i].p, $sformatf("w8_vec%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
